// File: rtl/carrier_acq_if.sv
// Carrier acquisition controller bus: phase-detector input and restart in,
// coarse offset, loop controls and status out.
interface carrier_acq_if #(
  parameter int PD_W  = 27,
  parameter int OFS_W = 31
);
  logic                    restart;
  logic signed [PD_W-1:0]  pd;
  logic signed [OFS_W-1:0] freq_ofs;
  logic                    loop_clr;
  logic                    bw_narrow;
  logic                    locked;
  logic [1:0]              state;
  logic [PD_W-1:0]         pd_avg;

  modport master (
    output restart, pd,
    input  freq_ofs, loop_clr, bw_narrow, locked, state, pd_avg
  );

  modport slave (
    input  restart, pd,
    output freq_ofs, loop_clr, bw_narrow, locked, state, pd_avg
  );
endinterface

// File: rtl/carrier_acq_ctrl.sv
// Carrier-recovery acquisition sequencer: frequency sweep with cleared loop,
// wide-band pull-in, narrow-band tracking, judged on windowed average |pd|.
module carrier_acq_ctrl #(
  parameter int PD_W       = 27,
  parameter int OFS_W      = 31,
  parameter int SWEEP_STEP = 268435,
  parameter int SWEEP_MAX  = 2684355,
  parameter int DWELL      = 4096,
  parameter int WIN_LOG2   = 10,
  parameter int PULL_WINS  = 16,
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 4,
  parameter int LOCK_THR   = 2**20,
  parameter int UNLOCK_THR = 2**22
) (
  input  logic          clk,
  input  logic          rst,
  carrier_acq_if.slave  bus
);

  localparam int ACC_W = PD_W + WIN_LOG2;
  localparam int DW_W  = $clog2(DWELL + 1);
  localparam int CNT_W = 16;

  localparam logic [DW_W-1:0]  DWELL_LAST  = DW_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_CNT - 1);
  localparam logic [CNT_W-1:0] UNLOCK_LAST = CNT_W'(UNLOCK_CNT - 1);
  localparam logic [CNT_W-1:0] PULL_LAST   = CNT_W'(PULL_WINS - 1);
  localparam logic [PD_W-1:0]  LOCK_THR_V   = PD_W'(LOCK_THR);
  localparam logic [PD_W-1:0]  UNLOCK_THR_V = PD_W'(UNLOCK_THR);
  localparam logic [OFS_W:0]   STEP_V = (OFS_W + 1)'(SWEEP_STEP);
  localparam logic [OFS_W:0]   MAX_V  = (OFS_W + 1)'(SWEEP_MAX);

  typedef enum logic [1:0] {
    ST_SWEEP  = 2'd0,
    ST_PULLIN = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t                  state_r;
  logic [DW_W-1:0]         dwell_cnt_r;
  logic [WIN_LOG2-1:0]     win_cnt_r;
  logic [ACC_W-1:0]        acc_r;
  logic [CNT_W-1:0]        good_cnt_r;
  logic [CNT_W-1:0]        bad_cnt_r;
  logic [CNT_W-1:0]        pull_cnt_r;
  logic [OFS_W-1:0]        mag_r;
  logic                    neg_r;
  logic signed [OFS_W-1:0] freq_ofs_r;
  logic                    loop_clr_r;
  logic                    bw_narrow_r;
  logic                    locked_r;
  logic [PD_W-1:0]         pd_avg_r;

  logic [PD_W-1:0]         pd_abs_s;
  logic [ACC_W-1:0]        acc_sum_s;
  logic [PD_W-1:0]         avg_s;
  logic                    win_end_s;
  logic                    good_win_s;
  logic                    bad_win_s;
  logic [OFS_W:0]          mag_plus_s;
  logic [OFS_W-1:0]        nxt_mag_s;
  logic                    nxt_neg_s;
  logic signed [OFS_W-1:0] nxt_ofs_s;

  // Two's-complement magnitude; the most negative code maps to 2^(PD_W-1) unsigned.
  function automatic logic [PD_W-1:0] abs_pd(input logic [PD_W-1:0] v);
    if (v[PD_W-1]) begin
      abs_pd = ~v + {{(PD_W-1){1'b0}}, 1'b1};
    end else begin
      abs_pd = v;
    end
  endfunction

  // Window accumulation and threshold classification of the completing window.
  always_comb begin
    pd_abs_s   = abs_pd(bus.pd);
    acc_sum_s  = acc_r + {{WIN_LOG2{1'b0}}, pd_abs_s};
    avg_s      = PD_W'(acc_sum_s >> WIN_LOG2);
    win_end_s  = (win_cnt_r == {WIN_LOG2{1'b1}});
    good_win_s = (avg_s < LOCK_THR_V);
    bad_win_s  = (avg_s > UNLOCK_THR_V);
  end

  // Next sweep point: 0, +S, -S, +2S, -2S, ... wrapping to 0 past SWEEP_MAX.
  always_comb begin
    mag_plus_s = {1'b0, mag_r} + STEP_V;
    nxt_mag_s  = mag_r;
    nxt_neg_s  = 1'b0;
    if (mag_r == {OFS_W{1'b0}}) begin
      if (STEP_V > MAX_V) begin
        nxt_mag_s = {OFS_W{1'b0}};
      end else begin
        nxt_mag_s = OFS_W'(STEP_V);
      end
    end else if (!neg_r) begin
      nxt_neg_s = 1'b1;
    end else if (mag_plus_s > MAX_V) begin
      nxt_mag_s = {OFS_W{1'b0}};
    end else begin
      nxt_mag_s = OFS_W'(mag_plus_s);
    end
    nxt_ofs_s = nxt_neg_s ? -$signed(nxt_mag_s) : $signed(nxt_mag_s);
  end

  // Sequencer: dwell, window decisions, lock/unlock and restart, with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_SWEEP;
      dwell_cnt_r <= {DW_W{1'b0}};
      win_cnt_r   <= {WIN_LOG2{1'b0}};
      acc_r       <= {ACC_W{1'b0}};
      good_cnt_r  <= {CNT_W{1'b0}};
      bad_cnt_r   <= {CNT_W{1'b0}};
      pull_cnt_r  <= {CNT_W{1'b0}};
      mag_r       <= {OFS_W{1'b0}};
      neg_r       <= 1'b0;
      freq_ofs_r  <= {OFS_W{1'b0}};
      loop_clr_r  <= 1'b1;
      bw_narrow_r <= 1'b0;
      locked_r    <= 1'b0;
      pd_avg_r    <= {PD_W{1'b0}};
    end else if (bus.restart) begin
      state_r     <= ST_SWEEP;
      dwell_cnt_r <= {DW_W{1'b0}};
      win_cnt_r   <= {WIN_LOG2{1'b0}};
      acc_r       <= {ACC_W{1'b0}};
      good_cnt_r  <= {CNT_W{1'b0}};
      bad_cnt_r   <= {CNT_W{1'b0}};
      pull_cnt_r  <= {CNT_W{1'b0}};
      mag_r       <= {OFS_W{1'b0}};
      neg_r       <= 1'b0;
      freq_ofs_r  <= {OFS_W{1'b0}};
      loop_clr_r  <= 1'b1;
      bw_narrow_r <= 1'b0;
      locked_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_SWEEP: begin
          if (dwell_cnt_r == DWELL_LAST) begin
            state_r     <= ST_PULLIN;
            loop_clr_r  <= 1'b0;
            dwell_cnt_r <= {DW_W{1'b0}};
            win_cnt_r   <= {WIN_LOG2{1'b0}};
            acc_r       <= {ACC_W{1'b0}};
            good_cnt_r  <= {CNT_W{1'b0}};
            pull_cnt_r  <= {CNT_W{1'b0}};
          end else begin
            dwell_cnt_r <= dwell_cnt_r + DW_W'(1);
          end
        end
        ST_PULLIN: begin
          win_cnt_r <= win_cnt_r + WIN_LOG2'(1);
          if (win_end_s) begin
            acc_r    <= {ACC_W{1'b0}};
            pd_avg_r <= avg_s;
            // Lock wins over the pull-in window limit when both land together.
            if (good_win_s && (good_cnt_r == LOCK_LAST)) begin
              state_r     <= ST_LOCKED;
              locked_r    <= 1'b1;
              bw_narrow_r <= 1'b1;
              bad_cnt_r   <= {CNT_W{1'b0}};
              good_cnt_r  <= {CNT_W{1'b0}};
            end else if (pull_cnt_r == PULL_LAST) begin
              state_r     <= ST_SWEEP;
              mag_r       <= nxt_mag_s;
              neg_r       <= nxt_neg_s;
              freq_ofs_r  <= nxt_ofs_s;
              loop_clr_r  <= 1'b1;
              dwell_cnt_r <= {DW_W{1'b0}};
            end else begin
              good_cnt_r <= good_win_s ? (good_cnt_r + CNT_W'(1)) : {CNT_W{1'b0}};
              pull_cnt_r <= pull_cnt_r + CNT_W'(1);
            end
          end else begin
            acc_r <= acc_sum_s;
          end
        end
        ST_LOCKED: begin
          win_cnt_r <= win_cnt_r + WIN_LOG2'(1);
          if (win_end_s) begin
            acc_r    <= {ACC_W{1'b0}};
            pd_avg_r <= avg_s;
            if (bad_win_s && (bad_cnt_r == UNLOCK_LAST)) begin
              state_r     <= ST_SWEEP;
              mag_r       <= {OFS_W{1'b0}};
              neg_r       <= 1'b0;
              freq_ofs_r  <= {OFS_W{1'b0}};
              loop_clr_r  <= 1'b1;
              bw_narrow_r <= 1'b0;
              locked_r    <= 1'b0;
              dwell_cnt_r <= {DW_W{1'b0}};
              bad_cnt_r   <= {CNT_W{1'b0}};
            end else begin
              bad_cnt_r <= bad_win_s ? (bad_cnt_r + CNT_W'(1)) : {CNT_W{1'b0}};
            end
          end else begin
            acc_r <= acc_sum_s;
          end
        end
        default: begin
          state_r     <= ST_SWEEP;
          dwell_cnt_r <= {DW_W{1'b0}};
          loop_clr_r  <= 1'b1;
          bw_narrow_r <= 1'b0;
          locked_r    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.state     = state_r;
  assign bus.freq_ofs  = freq_ofs_r;
  assign bus.loop_clr  = loop_clr_r;
  assign bus.bw_narrow = bw_narrow_r;
  assign bus.locked    = locked_r;
  assign bus.pd_avg    = pd_avg_r;

endmodule

// File: tb/tb_carrier_acq_ctrl.sv
// Directed and randomized bench for carrier_acq_ctrl with a behavioural
// reference model built from the sweep/window/lock rules.
module tb_carrier_acq_ctrl;

  localparam int PD_W       = 27;
  localparam int OFS_W      = 31;
  localparam int WIN_LOG2   = 2;
  localparam int WIN        = 1 << WIN_LOG2;
  localparam int DWELL      = 4;
  localparam int PULL_WINS  = 2;
  localparam int LOCK_CNT   = 2;
  localparam int UNLOCK_CNT = 2;
  localparam int LOCK_THR   = 100;
  localparam int UNLOCK_THR = 1000;
  localparam int SWEEP_STEP = 10;
  localparam int SWEEP_MAX  = 20;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  carrier_acq_if #(.PD_W(PD_W), .OFS_W(OFS_W)) bus ();

  carrier_acq_ctrl #(
    .PD_W(PD_W), .OFS_W(OFS_W), .SWEEP_STEP(SWEEP_STEP), .SWEEP_MAX(SWEEP_MAX),
    .DWELL(DWELL), .WIN_LOG2(WIN_LOG2), .PULL_WINS(PULL_WINS), .LOCK_CNT(LOCK_CNT),
    .UNLOCK_CNT(UNLOCK_CNT), .LOCK_THR(LOCK_THR), .UNLOCK_THR(UNLOCK_THR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase (0 sweep, 1 pull-in, 2 locked), sweep index, sample queue.
  int     m_state;
  int     m_k;
  int     m_dwell;
  int     m_good;
  int     m_bad;
  int     m_pull;
  longint m_avg;
  longint win_q[$];

  function automatic longint labs(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic longint sweep_off(input int k);
    if (k == 0) return 0;
    if (k % 2 == 1) return longint'((k + 1) / 2) * SWEEP_STEP;
    return -(longint'(k / 2) * SWEEP_STEP);
  endfunction

  function automatic int next_k(input int k);
    if (labs(sweep_off(k + 1)) > SWEEP_MAX) return 0;
    return k + 1;
  endfunction

  task automatic model_reset(input bit clear_avg);
    m_state = 0; m_k = 0; m_dwell = 0;
    m_good = 0; m_bad = 0; m_pull = 0;
    win_q.delete();
    if (clear_avg) m_avg = 0;
  endtask

  task automatic model_step(input logic r, input longint p);
    longint sum;
    longint avg;
    if (r) begin
      model_reset(1'b0);
    end else if (m_state == 0) begin
      m_dwell++;
      if (m_dwell == DWELL) begin
        m_state = 1; m_dwell = 0; m_good = 0; m_pull = 0;
        win_q.delete();
      end
    end else begin
      win_q.push_back(labs(p));
      if (win_q.size() == WIN) begin
        sum = 0;
        foreach (win_q[i]) sum += win_q[i];
        avg = sum / WIN;
        m_avg = avg;
        win_q.delete();
        if (m_state == 1) begin
          m_good = (avg < LOCK_THR) ? m_good + 1 : 0;
          m_pull++;
          if (m_good == LOCK_CNT) begin
            m_state = 2; m_bad = 0;
          end else if (m_pull == PULL_WINS) begin
            m_k = next_k(m_k); m_state = 0; m_dwell = 0;
          end
        end else begin
          m_bad = (avg > UNLOCK_THR) ? m_bad + 1 : 0;
          if (m_bad == UNLOCK_CNT) begin
            m_state = 0; m_k = 0; m_dwell = 0;
          end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("state",     bus.state,     m_state);
    chk("freq_ofs",  bus.freq_ofs,  sweep_off(m_k));
    chk("loop_clr",  bus.loop_clr,  (m_state == 0));
    chk("bw_narrow", bus.bw_narrow, (m_state == 2));
    chk("locked",    bus.locked,    (m_state == 2));
    chk("pd_avg",    bus.pd_avg,    m_avg);
  endtask

  task automatic cyc(input logic r, input longint p);
    bus.restart = r;
    bus.pd      = PD_W'(p);
    @(posedge clk);
    model_step(r, p);
    #1;
    check_all();
  endtask

  task automatic run(input int n, input longint p);
    for (int i = 0; i < n; i++) cyc(1'b0, p);
  endtask

  longint sweep_seen[$];
  longint sweep_exp[6];
  int     prev_state;
  longint rpd;
  int     seg_len;
  int     cat;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.restart = 1'b0;
    bus.pd = '0;
    model_reset(1'b1);
    #3;
    check_all();
    @(posedge clk); #1; check_all();
    rst = 1'b0;

    // Reset and dwell: run a little, then assert rst between edges.
    run(6, 777);
    #2 rst = 1'b1;
    #1;
    model_reset(1'b1);
    check_all();
    @(posedge clk); #1; check_all();
    rst = 1'b0;
    run(3, 0);
    chk("dwell_hold", bus.state, 0);
    run(1, 0);
    chk("dwell_exit_state", bus.state, 1);
    chk("dwell_exit_clr", bus.loop_clr, 0);

    // Lock on pd = -50: locked exactly 8 samples after pull-in entry.
    run(4, -50);
    chk("lock_avg1", bus.pd_avg, 50);
    chk("lock_early", bus.locked, 0);
    run(4, -50);
    chk("lock_locked", bus.locked, 1);
    chk("lock_bw", bus.bw_narrow, 1);
    chk("lock_avg2", bus.pd_avg, 50);

    // Loss of lock with a neutral window in between.
    run(4, 2000);
    chk("bad1_avg", bus.pd_avg, 2000);
    chk("bad1_locked", bus.locked, 1);
    run(4, 500);
    chk("neutral_locked", bus.locked, 1);
    run(4, 2000);
    chk("bad_again_locked", bus.locked, 1);
    run(4, 2000);
    chk("unlock_state", bus.state, 0);
    chk("unlock_locked", bus.locked, 0);
    chk("unlock_ofs", bus.freq_ofs, 0);

    // Sweep order and wrap with pd = 5000.
    cyc(1'b1, 5000);
    for (int i = 0; i < 75; i++) begin
      prev_state = int'(bus.state);
      cyc(1'b0, 5000);
      if (prev_state == 1 && bus.state == 2'd0) sweep_seen.push_back(longint'(bus.freq_ofs));
    end
    sweep_exp[0] = 10; sweep_exp[1] = -10; sweep_exp[2] = 20;
    sweep_exp[3] = -20; sweep_exp[4] = 0; sweep_exp[5] = 10;
    chk("sweep_count", sweep_seen.size(), 6);
    for (int i = 0; i < 6; i++)
      chk("sweep_ofs", (i < sweep_seen.size()) ? sweep_seen[i] : 64'sd999999, sweep_exp[i]);

    // Extreme negative input.
    cyc(1'b1, 0);
    run(4, 0);
    run(4, -(longint'(1) << 26));
    chk("extreme_avg", bus.pd_avg, longint'(1) << 26);

    // Restart coinciding with the lock decision.
    cyc(1'b1, 0);
    run(4, 0);
    run(7, -50);
    cyc(1'b1, -50);
    chk("restart_state", bus.state, 0);
    chk("restart_locked", bus.locked, 0);
    run(2, -50);
    chk("restart_hold", bus.locked, 0);

    // Randomized segments with occasional restart.
    for (int s = 0; s < 250; s++) begin
      cat = int'($urandom_range(0, 9));
      seg_len = int'($urandom_range(1, 12));
      for (int j = 0; j < seg_len; j++) begin
        if (cat < 5)       rpd = longint'($urandom_range(0, 198)) - 99;
        else if (cat < 7)  rpd = longint'($urandom_range(100, 1000)) * (($urandom_range(0, 1) == 0) ? 1 : -1);
        else if (cat < 9)  rpd = longint'($urandom_range(1001, 200000)) * (($urandom_range(0, 1) == 0) ? 1 : -1);
        else               rpd = ($urandom_range(0, 1) == 0) ? -(longint'(1) << 26) : (longint'(1) << 26) - 1;
        cyc(($urandom_range(0, 63) == 0), rpd);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
